serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
Multi-cycle, parametrised magnitude comparator that produces A==B, A>=B and A<B flags for WIDTH-bit operands. It scans the operands MSB-first, DIGIT bits per cycle, and stops at the first differing digit. It supports signed (two's complement) and unsigned modes, selected per operation. It replaces the fixed 2-bit combinational comparators in datapaths where area matters more than latency, and uses valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2.
DIGIT, 2, bits compared per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start_valid  input  1  request to compare a, b
start_ready  output  1  block can accept a request (high only in IDLE)
a  input  WIDTH  operand A, sampled at acceptance
b  input  WIDTH  operand B, sampled at acceptance
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled at acceptance
busy  output  1  high in COMPARE or DONE
result_valid  output  1  flags below are valid (high only in DONE)
result_ready  input  1  consumer accepts the result
a_eq_b  output  1  A == B
a_geq_b  output  1  A >= B
a_lt_b  output  1  A < B

Behaviour:
- NDIG = WIDTH/DIGIT. States: IDLE, COMPARE, DONE. Every output is registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Reset (synchronous, any state, including mid-compare): state goes to IDLE and the digit counter is cleared. Outputs after reset: start_ready=1, busy=0, result_valid=0, a_eq_b=0, a_geq_b=0, a_lt_b=0. Any in-flight operation is discarded silently.
- IDLE: start_ready=1. When start_valid && start_ready at an edge:
  - latch a, b and signed_mode;
  - set the digit index to NDIG-1;
  - go to COMPARE.
- COMPARE: at each edge, compare digit[idx] of the latched A against the same digit of latched B as unsigned values.
  - In signed mode, the MSB of the top digit (idx = NDIG-1) is inverted on both operands before comparing (offset-binary trick).
  - Digits differ: register a_lt_b = (A digit < B digit), a_geq_b = ~a_lt_b, a_eq_b = 0, then go to DONE (early termination).
  - Digits equal and idx == 0: register a_eq_b=1, a_geq_b=1, a_lt_b=0, then go to DONE.
  - Digits equal and idx > 0: decrement idx and stay in COMPARE.
- Latency: result_valid rises k edges after the acceptance edge, where k is the number of digits examined, 1 <= k <= NDIG.
- DONE: result_valid=1 and the flags are held stable.
  - On result_valid && result_ready: go to IDLE.
  - The flags keep their last values after the handshake until the next result is registered.
- Flag invariant: while result_valid=1, exactly one of a_eq_b / a_lt_b is high, and a_geq_b = ~a_lt_b.
- start_valid during COMPARE or DONE is ignored (start_ready=0); no queuing.
- Changes on a, b or signed_mode after acceptance have no effect.
- Throughput: one operation at most every k+2 cycles. A new start is accepted in the cycle after result consumption, because start_ready is decoded from IDLE only.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, COMPARE=2'd1, DONE=2'd2; 2'd3 is unused and recovers to IDLE;
  - the NDIG derivation;
  - a counter-width helper, clog2(NDIG) with a minimum of 1.
- Sub-module comparator_digit: purely combinational DIGIT-bit compare with a flip_msb input (signed top digit); outputs eq and lt. The top level holds the FSM, counter, operand registers and flag registers.

Test Plan:
1. WIDTH=8, DIGIT=2, unsigned, a=8'h5A, b=8'h5A -> result_valid 4 edges after accept; eq=1, geq=1, lt=0.
2. Unsigned, a=8'h40, b=8'h80 -> result_valid 1 edge after accept (top digit 01<10); lt=1, geq=0, eq=0. Same operands, signed_mode=1 (+64 vs -128) -> lt=0, geq=1, eq=0 after 1 edge.
3. Unsigned, a=8'h13, b=8'h12 -> difference only in the last digit, so latency is 4 edges; lt=0, geq=1, eq=0. Signed, a=8'hFF, b=8'hFE -> geq=1 after 4 edges.
4. Backpressure: hold result_ready=0 for 5 cycles and pulse start_valid with new operands -> flags and result_valid stay stable, start_ready=0, the pulse is ignored. Raise result_ready -> IDLE, then the next start is accepted the following cycle.
5. Assert reset 2 edges into the compare of case 1 -> next cycle: start_ready=1, busy=0, result_valid=0, all flags 0. No stale result appears afterwards.
6. Exhaustive sweep: WIDTH=2, DIGIT=1 and WIDTH=2, DIGIT=2, all 16 (A,B) pairs in both modes, plus 10k random WIDTH=16/DIGIT=4 pairs -> flags match the behavioural A==B / A>=B / A<B model, and the latency equals (number of leading equal digits + 1) capped at NDIG.

Source files
------------

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator.
// Holds the FSM state encoding, the digit-count derivation and the
// digit-counter width helper used by the top level.
package serial_magnitude_comparator_pkg;

  // 2'd3 is not a legal state; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Number of digits scanned per operand.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit-index counter width: clog2(ndig), never narrower than one bit.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bus of the serial magnitude comparator.
// Request side : start_valid/start_ready handshake carrying a, b, signed_mode.
// Result side  : result_valid/result_ready handshake carrying the three flags.
// busy reports that an operation is in flight (COMPARE or DONE).
// master = requester/consumer, slave = comparator.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic             a_eq_b;
  logic             a_geq_b;
  logic             a_lt_b;

  modport master (
    output start_valid, a, b, signed_mode, result_ready,
    input  start_ready, busy, result_valid, a_eq_b, a_geq_b, a_lt_b
  );

  modport slave (
    input  start_valid, a, b, signed_mode, result_ready,
    output start_ready, busy, result_valid, a_eq_b, a_geq_b, a_lt_b
  );
endinterface

// File: rtl/comparator_digit.sv
// Purely combinational DIGIT-bit unsigned compare.
// Ports: a_i, b_i   - digits to compare
//        flip_msb_i - invert the digit MSB on both sides (top digit of a
//                     signed compare: two's complement -> offset binary)
//        eq_o, lt_o - a == b, a < b after the optional flip
module comparator_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             flip_msb_i,
  output logic             eq_o,
  output logic             lt_o
);
  logic [DIGIT-1:0] msb_mask;
  logic [DIGIT-1:0] a_x;
  logic [DIGIT-1:0] b_x;

  always_comb begin
    msb_mask            = '0;
    msb_mask[DIGIT-1]   = flip_msb_i;
    a_x                 = a_i ^ msb_mask;
    b_x                 = b_i ^ msb_mask;
    eq_o                = (a_x == b_x);
    lt_o                = (a_x < b_x);
  end
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator. Scans latched operands MSB-first,
// DIGIT bits per cycle, stopping at the first differing digit, and
// registers A==B, A>=B, A<B (signed or unsigned per operation).
// Ports: clk   - rising-edge clock
//        reset - synchronous active-high reset (control and flags only)
//        bus   - slave side of serial_magnitude_comparator_if
// All outputs are registers or decodes of the state register.
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  serial_magnitude_comparator_if.slave bus
);
  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(NDIG - 1);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic             eq_q, geq_q, lt_q;
  logic             eq_d, geq_d, lt_d;
  logic             accept;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic             flip_msb, dig_eq, dig_lt;
  logic             start_ready, busy, result_valid;

  assign accept   = bus.start_valid && (state_q == IDLE);
  assign a_dig    = a_q[int'(idx_q) * DIGIT +: DIGIT];
  assign b_dig    = b_q[int'(idx_q) * DIGIT +: DIGIT];
  // Only the top digit carries the sign bit.
  assign flip_msb = signed_q && (idx_q == IDX_TOP);

  comparator_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i        (a_dig),
    .b_i        (b_dig),
    .flip_msb_i (flip_msb),
    .eq_o       (dig_eq),
    .lt_o       (dig_lt)
  );

  // Operand capture: data registers, no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      signed_q <= bus.signed_mode;
    end
  end

  // State, counter and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      geq_q   <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      geq_q   <= geq_d;
      lt_q    <= lt_d;
    end
  end

  // Next state, counter and flags
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    geq_d   = geq_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          state_d = COMPARE;
          idx_d   = IDX_TOP;
        end
      end
      COMPARE: begin
        if (!dig_eq) begin
          // Early termination on the first differing digit.
          eq_d    = 1'b0;
          lt_d    = dig_lt;
          geq_d   = !dig_lt;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          geq_d   = 1'b1;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    start_ready  = (state_q == IDLE);
    busy         = (state_q == COMPARE) || (state_q == DONE);
    result_valid = (state_q == DONE);
  end

  assign bus.start_ready  = start_ready;
  assign bus.busy         = busy;
  assign bus.result_valid = result_valid;
  assign bus.a_eq_b       = eq_q;
  assign bus.a_geq_b      = geq_q;
  assign bus.a_lt_b       = lt_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Testbench for serial_magnitude_comparator: four instances
// (8/2, 2/1, 2/2, 16/4) sharing operand/handshake drivers, each with
// its own start_valid. Expected results go into a scoreboard queue at
// stimulus time and are popped when result_valid is seen.
module tb_serial_magnitude_comparator;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a_v, b_v;
  logic        sm_v;
  logic [3:0]  sv;
  logic        rr;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int   sel;
    logic eq;
    logic lt;
    int   lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_magnitude_comparator_if #(.WIDTH(8))  if0 ();
  serial_magnitude_comparator_if #(.WIDTH(2))  if1 ();
  serial_magnitude_comparator_if #(.WIDTH(2))  if2 ();
  serial_magnitude_comparator_if #(.WIDTH(16)) if3 ();

  assign if0.start_valid = sv[0]; assign if0.a = a_v[7:0];  assign if0.b = b_v[7:0];
  assign if1.start_valid = sv[1]; assign if1.a = a_v[1:0];  assign if1.b = b_v[1:0];
  assign if2.start_valid = sv[2]; assign if2.a = a_v[1:0];  assign if2.b = b_v[1:0];
  assign if3.start_valid = sv[3]; assign if3.a = a_v;       assign if3.b = b_v;
  assign if0.signed_mode = sm_v;  assign if1.signed_mode = sm_v;
  assign if2.signed_mode = sm_v;  assign if3.signed_mode = sm_v;
  assign if0.result_ready = rr;   assign if1.result_ready = rr;
  assign if2.result_ready = rr;   assign if3.result_ready = rr;

  serial_magnitude_comparator #(.WIDTH(8),  .DIGIT(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  serial_magnitude_comparator #(.WIDTH(2),  .DIGIT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  serial_magnitude_comparator #(.WIDTH(2),  .DIGIT(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  wire [3:0] rv_w  = {if3.result_valid, if2.result_valid, if1.result_valid, if0.result_valid};
  wire [3:0] sr_w  = {if3.start_ready,  if2.start_ready,  if1.start_ready,  if0.start_ready};
  wire [3:0] bsy_w = {if3.busy,         if2.busy,         if1.busy,         if0.busy};
  wire [3:0] eq_w  = {if3.a_eq_b,       if2.a_eq_b,       if1.a_eq_b,       if0.a_eq_b};
  wire [3:0] geq_w = {if3.a_geq_b,      if2.a_geq_b,      if1.a_geq_b,      if0.a_geq_b};
  wire [3:0] lt_w  = {if3.a_lt_b,       if2.a_lt_b,       if1.a_lt_b,       if0.a_lt_b};

  function automatic int width_of(input int sel);
    case (sel)
      0: return 8;
      3: return 16;
      default: return 2;
    endcase
  endfunction

  function automatic int digit_of(input int sel);
    case (sel)
      0: return 2;
      1: return 1;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  // Behavioural reference: integer compare plus leading-equal-digit count.
  task automatic model(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, output logic eq, output logic lt, output int lat);
    int     w, d, ndig, lead, dm;
    longint m, va, vb;
    w    = width_of(sel);
    d    = digit_of(sel);
    ndig = w / d;
    m    = (longint'(1) << w) - 1;
    va   = longint'(a) & m;
    vb   = longint'(b) & m;
    if (sm && va[w-1]) va = va - (longint'(1) << w);
    if (sm && vb[w-1]) vb = vb - (longint'(1) << w);
    eq   = (va == vb);
    lt   = (va < vb);
    dm   = (1 << d) - 1;
    lead = 0;
    for (int i = ndig - 1; i >= 0; i--) begin
      if (((int'(a) >> (i * d)) & dm) == ((int'(b) >> (i * d)) & dm)) lead++;
      else break;
    end
    lat = (lead + 1 > ndig) ? ndig : lead + 1;
  endtask

  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, input logic exp_eq, input logic exp_lt, input int exp_lat);
    exp_t e;
    int   lat;
    @(negedge clk);
    checks++;
    if (sr_w[sel] !== 1'b1) begin
      errors++;
      $display("FAIL start_ready_idle sel=%0d got=%b exp=1", sel, sr_w[sel]);
    end
    a_v = a; b_v = b; sm_v = sm; sv[sel] = 1'b1;
    e.sel = sel; e.eq = exp_eq; e.lt = exp_lt; e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    sv[sel] = 1'b0;
    // Operand changes after acceptance must not matter.
    a_v = 16'($urandom); b_v = 16'($urandom); sm_v = ~sm;
    lat = 0;
    while (rv_w[sel] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (rv_w[sel] !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout sel=%0d a=%h b=%h got=no result exp=result", sel, a, b);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL latency sel=%0d a=%h b=%h sm=%b got=%0d exp=%0d", sel, a, b, sm, lat, e.lat);
      end
      checks++;
      if (eq_w[sel] !== e.eq) begin
        errors++;
        $display("FAIL a_eq_b sel=%0d a=%h b=%h sm=%b got=%b exp=%b", sel, a, b, sm, eq_w[sel], e.eq);
      end
      checks++;
      if (lt_w[sel] !== e.lt) begin
        errors++;
        $display("FAIL a_lt_b sel=%0d a=%h b=%h sm=%b got=%b exp=%b", sel, a, b, sm, lt_w[sel], e.lt);
      end
      checks++;
      if (geq_w[sel] !== !e.lt) begin
        errors++;
        $display("FAIL a_geq_b sel=%0d a=%h b=%h sm=%b got=%b exp=%b", sel, a, b, sm, geq_w[sel], !e.lt);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({sr_w[s], bsy_w[s], rv_w[s], eq_w[s], geq_w[s], lt_w[s]} !== 6'b100000) begin
        errors++;
        $display("FAIL reset_outputs sel=%0d got=%b exp=100000 (sr,busy,rv,eq,geq,lt)", s,
                 {sr_w[s], bsy_w[s], rv_w[s], eq_w[s], geq_w[s], lt_w[s]});
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_full_scan();
    do_op(0, 16'h005A, 16'h005A, 1'b0, 1'b1, 1'b0, 4);
    do_op(0, 16'h0013, 16'h0012, 1'b0, 1'b0, 1'b0, 4);
    do_op(0, 16'h00FF, 16'h00FE, 1'b1, 1'b0, 1'b0, 4);
  endtask

  task automatic test_early_termination();
    do_op(0, 16'h0040, 16'h0080, 1'b0, 1'b0, 1'b1, 1);
    do_op(0, 16'h0040, 16'h0080, 1'b1, 1'b0, 1'b0, 1);
    do_op(0, 16'h0080, 16'h007F, 1'b1, 1'b0, 1'b1, 1);
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    rr = 1'b0;
    a_v = 16'h0040; b_v = 16'h0080; sm_v = 1'b0; sv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv[0] = 1'b0;
    lat = 0;
    while (rv_w[0] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL bp_latency got=%0d exp=1", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rv_w[0], sr_w[0], eq_w[0], geq_w[0], lt_w[0]} !== 5'b10001) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got=%b exp=10001 (rv,sr,eq,geq,lt)", c,
                 {rv_w[0], sr_w[0], eq_w[0], geq_w[0], lt_w[0]});
      end
      sv[0] = (c == 1);
      if (c == 1) begin a_v = 16'h005A; b_v = 16'h005A; end
    end
    sv[0] = 1'b0;
    rr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sr_w[0], rv_w[0], lt_w[0], geq_w[0]} !== 4'b1010) begin
      errors++;
      $display("FAIL bp_release got=%b exp=1010 (sr,rv,lt,geq)", {sr_w[0], rv_w[0], lt_w[0], geq_w[0]});
    end
    // Start in the very cycle IDLE is reached.
    a_v = 16'h005A; b_v = 16'h005A; sm_v = 1'b0; sv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv[0] = 1'b0;
    checks++;
    if ({sr_w[0], bsy_w[0]} !== 2'b01) begin
      errors++;
      $display("FAIL bp_next_accept got=%b exp=01 (sr,busy)", {sr_w[0], bsy_w[0]});
    end
    lat = 0;
    while (rv_w[0] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({lat == 4, eq_w[0], geq_w[0], lt_w[0]} !== 4'b1110) begin
      errors++;
      $display("FAIL bp_next_result got=lat%0d eq%b geq%b lt%b exp=lat4 eq1 geq1 lt0",
               lat, eq_w[0], geq_w[0], lt_w[0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_v = 16'h005A; b_v = 16'h005A; sm_v = 1'b0; sv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({sr_w[0], bsy_w[0], rv_w[0], eq_w[0], geq_w[0], lt_w[0]} !== 6'b100000) begin
      errors++;
      $display("FAIL mid_reset got=%b exp=100000 (sr,busy,rv,eq,geq,lt)",
               {sr_w[0], bsy_w[0], rv_w[0], eq_w[0], geq_w[0], lt_w[0]});
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rv_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL stale_result cycle=%0d got=%b exp=0", c, rv_w[0]);
      end
    end
  endtask

  task automatic test_sweep_small();
    logic e_eq, e_lt;
    int   e_lat;
    for (int s = 1; s <= 2; s++)
      for (int m = 0; m < 2; m++)
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++) begin
            model(s, 16'(a), 16'(b), m[0], e_eq, e_lt, e_lat);
            do_op(s, 16'(a), 16'(b), m[0], e_eq, e_lt, e_lat);
          end
  endtask

  task automatic test_random_wide();
    logic [15:0] a, b;
    logic        sm;
    logic        e_eq, e_lt;
    int          e_lat;
    for (int i = 0; i < 10000; i++) begin
      a  = 16'($urandom);
      sm = 1'($urandom);
      case (i % 4)
        0: b = a ^ 16'($urandom_range(0, 255));
        1: b = a ^ 16'($urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      model(3, a, b, sm, e_eq, e_lt, e_lat);
      do_op(3, a, b, sm, e_eq, e_lt, e_lat);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rr = 1'b1; sv = '0; a_v = '0; b_v = '0; sm_v = 1'b0;
    test_reset();
    test_full_scan();
    test_early_termination();
    test_backpressure();
    test_reset_mid();
    test_sweep_small();
    test_random_wide();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
